// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// and buffers one returned instruction in a skid register while decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        nop,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_pype0,
  output logic [31:0] PCp4_pype0,
  output logic [31:0] Instraction_pype,
  output logic [4:0]  fornop_register1_pype,
  output logic [4:0]  fornop_register2_pype
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] outst_pc_q, outst_pc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_pcp4_q, out_pcp4_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        rsp_ok;
  logic        accept;

  // Only a response to a live (non-squashed) request is ever consumed.
  assign rsp_ok = (state_q == S_WAIT) && imem_rvalid;
  assign accept = imem_req && imem_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      outst_pc_q   <= RESET_PC;
      out_pc_q     <= '0;
      out_pcp4_q   <= '0;
      out_instr_q  <= BUBBLE;
      skid_vld_q   <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= BUBBLE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      outst_pc_q   <= outst_pc_d;
      out_pc_q     <= out_pc_d;
      out_pcp4_q   <= out_pcp4_d;
      out_instr_q  <= out_instr_d;
      skid_vld_q   <= skid_vld_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // Output/skid datapath
  always_comb begin
    out_pc_d     = out_pc_q;
    out_pcp4_d   = out_pcp4_q;
    out_instr_d  = out_instr_q;
    skid_vld_d   = skid_vld_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (branch_taken) begin
      out_pc_d    = '0;
      out_pcp4_d  = '0;
      out_instr_d = BUBBLE;
      skid_vld_d  = 1'b0;
    end else if (nop) begin
      out_pc_d    = '0;
      out_pcp4_d  = '0;
      out_instr_d = BUBBLE;
      // A skid is never full while a request is in flight, so a response here lands in an empty skid.
      if (rsp_ok) begin
        skid_vld_d   = 1'b1;
        skid_pc_d    = outst_pc_q;
        skid_instr_d = imem_rdata;
      end
    end else if (!keep) begin
      if (skid_vld_q) begin
        out_pc_d    = skid_pc_q;
        out_pcp4_d  = skid_pc_q + 32'd4;
        out_instr_d = skid_instr_q;
        skid_vld_d  = rsp_ok;
        if (rsp_ok) begin
          skid_pc_d    = outst_pc_q;
          skid_instr_d = imem_rdata;
        end
      end else if (rsp_ok) begin
        out_pc_d    = outst_pc_q;
        out_pcp4_d  = outst_pc_q + 32'd4;
        out_instr_d = imem_rdata;
      end else begin
        out_pc_d    = '0;
        out_pcp4_d  = '0;
        out_instr_d = BUBBLE;
      end
    end else if (rsp_ok) begin
      skid_vld_d   = 1'b1;
      skid_pc_d    = outst_pc_q;
      skid_instr_d = imem_rdata;
    end
  end

  // PC and outstanding-address bookkeeping
  always_comb begin
    pc_d       = pc_q;
    outst_pc_d = outst_pc_q;
    if (branch_taken)
      pc_d = branch_target & ~32'h3;
    else if (accept)
      pc_d = pc_q + 32'd4;
    if (accept)
      outst_pc_d = pc_q;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (branch_taken)
          state_d = imem_rvalid ? S_IDLE : S_DROP;
        else if (imem_rvalid)
          state_d = accept ? S_WAIT : S_IDLE;
      end
      S_DROP: if (imem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: a request goes out only when the skid will be empty after this cycle.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    if (!rst && !branch_taken && !skid_vld_d &&
        ((state_q == S_IDLE) || rsp_ok))
      imem_req = 1'b1;
  end

  assign PC_pype0              = out_pc_q;
  assign PCp4_pype0            = out_pcp4_q;
  assign Instraction_pype      = out_instr_q;
  assign fornop_register1_pype = out_instr_q[19:15];
  assign fornop_register2_pype = out_instr_q[24:20];

endmodule
